iq_stream_mux: RTL and testbench



---
 rtl/iq_stream_mux.sv | 149 ++++++++++++++
 tb/tb_iq_stream_mux.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_stream_mux.sv
// Purpose: pulls whole IQ words from one of NUM_CH RX FIFOs and serialises them MSB-first as tagged bytes.
// Latency: pull 1 cycle after the IDLE decision, first byte valid 3 cycles after it, 4-cycle gap between words.
// Backpressure: the host paces bytes with i_byte_req, there is no prefetch, and strobes with no valid byte count as underruns.
module iq_stream_mux #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int WORD_W = 32
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst_b,
  input  logic [1:0]               i_mode,
  input  logic [CH_W-1:0]          i_ch_sel,
  output logic [NUM_CH-1:0]        o_fifo_pull,
  input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
  input  logic [NUM_CH-1:0]        i_fifo_empty,
  input  logic                     i_byte_req,
  output logic [7:0]               o_byte,
  output logic                     o_byte_valid,
  output logic [CH_W-1:0]          o_ch_tag,
  output logic [7:0]               o_underrun_cnt,
  output logic [15:0]              o_word_cnt
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, PULL, WAIT, SEND} state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  byte_idx;

  logic              fix_hit;
  logic              rr_hit;
  logic [CH_W-1:0]   rr_cand;
  int                rr_dist;
  int                rr_best;
  logic              cand_vld;
  logic [CH_W-1:0]   cand;
  logic [WORD_W-1:0] word_sel;

  // The presented byte is always the top of the shift register; it reads 0 once a word is fully shifted out.
  assign o_byte = shreg[WORD_W-1 -: 8];

  // Fixed mode: selected channel exists and has data (out-of-range selections never match).
  always_comb begin
    fix_hit = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (i_ch_sel == CH_W'(ch) && !i_fifo_empty[ch]) fix_hit = 1'b1;
    end
  end

  // Round-robin: non-empty channel with the smallest forward distance from rr_ptr.
  always_comb begin
    rr_cand = '0;
    rr_best = NUM_CH;
    rr_dist = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rr_dist = (ch + NUM_CH - int'(rr_ptr)) % NUM_CH;
      if (!i_fifo_empty[ch] && rr_dist < rr_best) begin
        rr_best = rr_dist;
        rr_cand = CH_W'(ch);
      end
    end
    rr_hit = (rr_best < NUM_CH);
  end

  // Candidate channel for the IDLE decision; modes 0 and 3 never offer one.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    case (i_mode)
      2'd1: begin
        cand_vld = fix_hit;
        cand     = i_ch_sel;
      end
      2'd2: begin
        cand_vld = rr_hit;
        cand     = rr_cand;
      end
      default: ;
    endcase
  end

  // Read-data slice of the channel currently being fetched.
  always_comb begin
    word_sel = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (o_ch_tag == CH_W'(ch)) word_sel = i_fifo_data[ch*WORD_W +: WORD_W];
    end
  end

  // Word fetch / serialise state machine with registered pull, valid, tag and word count.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state        <= IDLE;
      o_fifo_pull  <= '0;
      o_byte_valid <= 1'b0;
      o_ch_tag     <= '0;
      o_word_cnt   <= '0;
      rr_ptr       <= '0;
      shreg        <= '0;
      byte_idx     <= '0;
    end else begin
      o_fifo_pull <= '0;
      case (state)
        IDLE: begin
          if (cand_vld) begin
            o_ch_tag    <= cand;
            o_fifo_pull <= NUM_CH'(1) << cand;
            state       <= PULL;
            if (i_mode == 2'd2) rr_ptr <= CH_W'((int'(cand) + 1) % NUM_CH);
          end
        end
        PULL: state <= WAIT;
        WAIT: begin
          shreg        <= word_sel;
          byte_idx     <= '0;
          o_byte_valid <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (i_byte_req) begin
            shreg    <= shreg << 8;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_IDX) begin
              o_word_cnt   <= o_word_cnt + 16'd1;
              o_byte_valid <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of host strobes that arrive with no byte on offer.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_underrun_cnt <= '0;
    end else if (i_byte_req && state != SEND && o_underrun_cnt != 8'hFF) begin
      o_underrun_cnt <= o_underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_iq_stream_mux.sv
module tb_iq_stream_mux;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;
  localparam int WORD_W = 32;

  logic                     clk = 1'b0;
  logic                     rst_b;
  logic [1:0]               mode;
  logic [CH_W-1:0]          ch_sel;
  logic [NUM_CH-1:0]        fifo_pull;
  logic [NUM_CH*WORD_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        fifo_empty;
  logic                     byte_req;
  logic [7:0]               byte_out;
  logic                     byte_vld;
  logic [CH_W-1:0]          ch_tag;
  logic [7:0]               underrun_cnt;
  logic [15:0]              word_cnt;

  iq_stream_mux #(.NUM_CH(NUM_CH), .CH_W(CH_W), .WORD_W(WORD_W)) dut (
    .i_sys_clk      (clk),
    .i_rst_b        (rst_b),
    .i_mode         (mode),
    .i_ch_sel       (ch_sel),
    .o_fifo_pull    (fifo_pull),
    .i_fifo_data    (fifo_data),
    .i_fifo_empty   (fifo_empty),
    .i_byte_req     (byte_req),
    .o_byte         (byte_out),
    .o_byte_valid   (byte_vld),
    .o_ch_tag       (ch_tag),
    .o_underrun_cnt (underrun_cnt),
    .o_word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO contents and the expected host-side byte stream
  logic [31:0]     fq0[$];
  logic [31:0]     fq1[$];
  logic [7:0]      exp_byte[$];
  logic [CH_W-1:0] exp_tag[$];
  logic [31:0]     pend_word[NUM_CH];
  bit              pend_vld[NUM_CH];
  int              pulls[NUM_CH];
  int              model_pulls[NUM_CH];
  int              model_rr;
  int              strobes;
  int              consumed;
  int              cyc;
  int              last_pull_cyc;
  int              last_end_cyc;
  bit              gap_on;
  bit              prev_vld;
  int              vld_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic add_word(input int ch, input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      exp_byte.push_back(w[b*8 +: 8]);
      exp_tag.push_back(CH_W'(ch));
    end
    model_pulls[ch]++;
  endtask

  // Expected word order for the current FIFO contents under a given mode.
  task automatic plan(input int md, input int sel);
    logic [31:0] c0[$];
    logic [31:0] c1[$];
    logic [31:0] w;
    int ch;
    c0 = fq0;
    c1 = fq1;
    if (md == 1) begin
      if (sel == 0) foreach (c0[i]) add_word(0, c0[i]);
      else if (sel == 1) foreach (c1[i]) add_word(1, c1[i]);
    end else if (md == 2) begin
      while (c0.size() + c1.size() > 0) begin
        ch = model_rr;
        if ((ch == 0 && c0.size() == 0) || (ch == 1 && c1.size() == 0)) ch = 1 - ch;
        if (ch == 0) w = c0.pop_front();
        else w = c1.pop_front();
        add_word(ch, w);
        model_rr = (ch + 1) % NUM_CH;
      end
    end
  endtask

  // One clock cycle, entered and left at the falling edge: observe, model the FIFOs, drive the strobe.
  task automatic cycle(input bit req);
    if (byte_vld) vld_cycles++;
    if (gap_on && byte_vld && !prev_vld && last_end_cyc >= 0)
      chk("word_gap", 32'(cyc - last_end_cyc), 32'd4);
    prev_vld = byte_vld;
    fifo_data = {$urandom, $urandom};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (pend_vld[ch]) fifo_data[ch*WORD_W +: WORD_W] = pend_word[ch];
      pend_vld[ch] = 1'b0;
    end
    if (fifo_pull != '0) begin
      last_pull_cyc = cyc;
      chk("pull_onehot", 32'($countones(fifo_pull)), 32'd1);
      if (fifo_pull[0]) begin
        pulls[0]++;
        chk("pull0_nonempty", 32'(fq0.size() != 0), 32'd1);
        if (fq0.size() != 0) begin
          pend_word[0] = fq0.pop_front();
          pend_vld[0]  = 1'b1;
        end
      end
      if (fifo_pull[1]) begin
        pulls[1]++;
        chk("pull1_nonempty", 32'(fq1.size() != 0), 32'd1);
        if (fq1.size() != 0) begin
          pend_word[1] = fq1.pop_front();
          pend_vld[1]  = 1'b1;
        end
      end
    end
    fifo_empty = {fq1.size() == 0, fq0.size() == 0};
    byte_req = req;
    if (req) begin
      strobes++;
      if (byte_vld) begin
        if (exp_byte.size() == 0) begin
          chk("extra_byte_vld", 32'(byte_vld), 32'd0);
        end else begin
          chk("byte", 32'(byte_out), 32'(exp_byte.pop_front()));
          chk("tag", 32'(ch_tag), 32'(exp_tag.pop_front()));
          consumed++;
          if (consumed % 4 == 0) last_end_cyc = cyc;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic end_checks();
    chk("vld_idle", 32'(byte_vld), 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) chk("pull_count", 32'(pulls[ch]), 32'(model_pulls[ch]));
    chk("word_cnt", 32'(word_cnt), 32'(16'(consumed / 4)));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(sat255(strobes - consumed)));
  endtask

  // Strobe randomly until the expected stream is consumed, then idle and check totals.
  task automatic drain(input int pct, input int budget);
    int n;
    n = 0;
    while (exp_byte.size() > 0 && n < budget) begin
      cycle(int'($urandom_range(0, 99)) < pct);
      n++;
    end
    chk("drain_done", 32'(exp_byte.size()), 32'd0);
    repeat (8) cycle(1'b0);
    end_checks();
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!byte_vld && n < 20) begin
      cycle(1'b0);
      n++;
    end
    chk(tag, 32'(byte_vld), 32'd1);
  endtask

  initial begin
    int start;
    int p0;
    int v0;
    int n0;
    int n1;
    int sel;
    logic [31:0] w;

    rst_b = 1'b0; mode = 2'd0; ch_sel = '0; byte_req = 1'b0;
    fifo_empty = '1; fifo_data = '0;
    model_rr = 0; strobes = 0; consumed = 0; cyc = 0; last_pull_cyc = -1;
    last_end_cyc = -1; gap_on = 1'b0; prev_vld = 1'b0; vld_cycles = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pulls[ch] = 0; model_pulls[ch] = 0; pend_vld[ch] = 1'b0; pend_word[ch] = '0;
    end
    #1;
    chk("rst_pull", 32'(fifo_pull), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_vld", 32'(byte_vld), 32'd0);
    chk("rst_tag", 32'(ch_tag), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;
    repeat (3) cycle(1'b0);

    // fixed channel 0: latency, byte order, tag
    mode = 2'd1; ch_sel = 2'd0;
    repeat (2) cycle(1'b0);
    fq0.push_back(32'hA1B2C3D4);
    add_word(0, 32'hA1B2C3D4);
    start = cyc;
    while (!byte_vld && cyc - start < 20) cycle(1'b0);
    chk("fix_latency", 32'(cyc - start), 32'd3);
    chk("fix_pull_cycle", 32'(last_pull_cyc - start), 32'd1);
    drain(100, 50);

    // round-robin interleave with back-to-back strobes
    mode = 2'd0;
    fq0.push_back(32'h11111111); fq0.push_back(32'h33333333);
    fq1.push_back(32'h22222222); fq1.push_back(32'h44444444);
    cycle(1'b0);
    plan(2, 0);
    mode = 2'd2; gap_on = 1'b1; last_end_cyc = -1;
    drain(100, 200);
    gap_on = 1'b0;

    // round-robin skips an empty channel
    mode = 2'd0;
    p0 = pulls[0];
    for (int i = 0; i < 3; i++) fq1.push_back($urandom);
    cycle(1'b0);
    plan(2, 0);
    mode = 2'd2;
    drain(70, 300);
    chk("skip_no_pull0", 32'(pulls[0]), 32'(p0));

    // randomized round-robin and fixed-channel runs
    for (int t = 0; t < 5; t++) begin
      mode = 2'd0;
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(1, 4);
      for (int i = 0; i < n0; i++) fq0.push_back($urandom);
      for (int i = 0; i < n1; i++) fq1.push_back($urandom);
      cycle(1'b0);
      if (t < 3) begin
        plan(2, 0);
        mode = 2'd2;
      end else begin
        sel = $urandom_range(0, 1);
        ch_sel = CH_W'(sel);
        plan(1, sel);
        mode = 2'd1;
      end
      drain(int'($urandom_range(30, 100)), 1000);
      mode = 2'd0;
      fq0.delete(); fq1.delete();
      cycle(1'b0);
    end

    // underrun saturation in mode 0 with data waiting
    mode = 2'd0;
    fq0.push_back($urandom);
    v0 = vld_cycles;
    p0 = pulls[0] + pulls[1];
    repeat (300) cycle(1'b1);
    cycle(1'b0);
    chk("underrun_sat", 32'(underrun_cnt), 32'd255);
    chk("underrun_model", 32'(underrun_cnt), 32'(sat255(strobes - consumed)));
    chk("underrun_no_vld", 32'(vld_cycles), 32'(v0));
    chk("underrun_no_pull", 32'(pulls[0] + pulls[1]), 32'(p0));
    fq0.delete();
    cycle(1'b0);

    // mode change mid-word completes the word, then stops fetching
    ch_sel = 2'd0;
    fq0.push_back(32'hDEADBEEF); fq0.push_back(32'h12345678);
    add_word(0, 32'hDEADBEEF);
    mode = 2'd1;
    wait_vld("mw_start");
    cycle(1'b1);
    cycle(1'b1);
    mode = 2'd0;
    drain(100, 50);
    chk("mw_fifo_left", 32'(fq0.size()), 32'd1);

    // out-of-range fixed channel stays idle
    ch_sel = 2'd3; mode = 2'd1;
    repeat (10) cycle(1'b0);
    chk("sel3_no_pull", 32'(pulls[0] + pulls[1]), 32'(model_pulls[0] + model_pulls[1]));
    chk("sel3_no_vld", 32'(byte_vld), 32'd0);
    mode = 2'd0;
    fq0.delete();
    cycle(1'b0);

    // asynchronous reset while byte 1 of a channel-1 word is presented
    w = $urandom;
    ch_sel = 2'd1;
    fq1.push_back(w);
    add_word(1, w);
    mode = 2'd1;
    wait_vld("rst_mid_start");
    cycle(1'b1);
    byte_req = 1'b0;
    chk("rst_mid_byte1", 32'(byte_out), 32'(w[23:16]));
    chk("rst_mid_tag", 32'(ch_tag), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rst_mid_pull", 32'(fifo_pull), 32'd0);
    chk("rst_mid_byte", 32'(byte_out), 32'd0);
    chk("rst_mid_vld", 32'(byte_vld), 32'd0);
    chk("rst_mid_tag0", 32'(ch_tag), 32'd0);
    chk("rst_mid_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_mid_word_cnt", 32'(word_cnt), 32'd0);
    mode = 2'd0;
    exp_byte.delete(); exp_tag.delete();
    strobes = 0; consumed = 0; model_rr = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pulls[ch] = 0; model_pulls[ch] = 0; pend_vld[ch] = 1'b0;
    end
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) cycle(1'b0);
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("post_rst_vld", 32'(byte_vld), 32'd0);
    fq1.push_back($urandom);
    plan(1, 1);
    mode = 2'd1;
    drain(100, 50);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
